// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: 32 x DATA_W architectural register file for the
// multicycle MIPS datapath. It has two registered read ports with
// write-through bypass, and a write-pending scoreboard. Multi-cycle
// producers use the scoreboard to reserve their destination register.
module regbank_scoreboard #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              reserve,
  input  logic [4:0]        reserve_reg,
  output logic              hazard1,
  output logic              hazard2,
  output logic              stall,
  output logic [31:0]       pending
);

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       pending_q;
  logic [31:0]       pending_d;
  logic              write_en;
  logic              bypass1;
  logic              bypass2;

  // Writes to register 0 are dropped, so it stays 0 and never becomes pending.
  assign write_en = RegWrite && (WriteReg != 5'd0);
  assign bypass1  = RegWrite && (WriteReg == ReadReg1);
  assign bypass2  = RegWrite && (WriteReg == ReadReg2);

  // Next scoreboard: the write clears first, then a reservation sets the bit.
  // A reserve and a write to the same index therefore leave the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (write_en)
      pending_d[WriteReg] = 1'b0;
    if (reserve && (reserve_reg != 5'd0))
      pending_d[reserve_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Register array, scoreboard, read latches and hazard flags. All of them
  // are cleared by a synchronous reset, which wins over writes and reserves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 29) ? SP_INIT : '0;
      pending_q <= '0;
      ReadData1 <= '0;
      ReadData2 <= '0;
      hazard1   <= 1'b0;
      hazard2   <= 1'b0;
    end else begin
      if (write_en)
        regs[WriteReg] <= WriteData;
      pending_q <= pending_d;

      if (ReadReg1 == 5'd0)
        ReadData1 <= '0;
      else if (bypass1)
        ReadData1 <= WriteData;
      else
        ReadData1 <= regs[ReadReg1];

      if (ReadReg2 == 5'd0)
        ReadData2 <= '0;
      else if (bypass2)
        ReadData2 <= WriteData;
      else
        ReadData2 <= regs[ReadReg2];

      hazard1 <= pending_q[ReadReg1] & ~bypass1;
      hazard2 <= pending_q[ReadReg2] & ~bypass2;
    end
  end

  assign stall   = hazard1 | hazard2;
  assign pending = pending_q;

endmodule

// File: tb/tb_regbank_scoreboard.sv
// tb_regbank_scoreboard: randomized and directed checks of regbank_scoreboard
// against a behavioural model. The model is a plain register array plus a
// pending bitmap, updated with the architectural rules once per cycle.
module tb_regbank_scoreboard;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              reserve;
  logic [4:0]        reserve_reg;
  logic              hazard1;
  logic              hazard2;
  logic              stall;
  logic [31:0]       pending;

  int total;
  int bad;

  logic [DATA_W-1:0] model_regs [32];
  logic [31:0]       model_pending;

  regbank_scoreboard #(.DATA_W(DATA_W), .SP_INIT(227)) dut (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .reserve(reserve), .reserve_reg(reserve_reg),
    .hazard1(hazard1), .hazard2(hazard2), .stall(stall),
    .pending(pending)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Puts a reset value into the model's architectural state.
  task automatic modelReset();
    for (int i = 0; i < 32; i++)
      model_regs[i] = (i == 29) ? 32'd227 : 32'd0;
    model_pending = '0;
  endtask

  // Drives one cycle of inputs and advances the model across the edge.
  // It then checks every output shortly after that edge.
  task automatic applyStimulus(input logic rst, input logic we,
                               input logic [4:0] wr, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic rv, input logic [4:0] rr);
    logic [31:0] e1, e2;
    logic        h1, h2;
    reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2; reserve = rv; reserve_reg = rr;
    if (rst) begin
      e1 = 0; e2 = 0; h1 = 0; h2 = 0;
      modelReset();
    end else begin
      if (r1 == 0)                 e1 = 0;
      else if (we && wr == r1)     e1 = wd;
      else                         e1 = model_regs[r1];
      if (r2 == 0)                 e2 = 0;
      else if (we && wr == r2)     e2 = wd;
      else                         e2 = model_regs[r2];
      h1 = model_pending[r1] && !(we && wr == r1);
      h2 = model_pending[r2] && !(we && wr == r2);
      if (we && wr != 0) begin
        model_regs[wr]    = wd;
        model_pending[wr] = 1'b0;
      end
      if (rv && rr != 0)
        model_pending[rr] = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput("ReadData1", ReadData1, e1);
    checkOutput("ReadData2", ReadData2, e2);
    checkOutput("hazard1", {31'd0, hazard1}, {31'd0, h1});
    checkOutput("hazard2", {31'd0, hazard2}, {31'd0, h2});
    checkOutput("stall", {31'd0, stall}, {31'd0, h1 | h2});
    checkOutput("pending", pending, model_pending);
  endtask

  // Produces a random register index. Half the time it picks from a small
  // range so that the write, read and reserve indices collide often.
  function automatic logic [4:0] pickReg();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Directed sequences first, then a long randomized run.
  initial begin
    total = 0;
    bad   = 0;
    modelReset();

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 29, 0, 0, 0);
    checkOutput("sp_reset", ReadData1, 32'd227);
    for (int i = 0; i < 32; i += 2)
      applyStimulus(0, 0, 0, 0, 5'(i), 5'(i + 1), 0, 0);
    checkOutput("stall_reset", {31'd0, stall}, 32'd0);

    applyStimulus(0, 1, 8, 32'hDEADBEEF, 8, 0, 0, 0);
    checkOutput("bypass8", ReadData1, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 8, 0, 0, 0);
    checkOutput("array8", ReadData1, 32'hDEADBEEF);

    applyStimulus(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reg0", ReadData1, 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 31);
    applyStimulus(0, 0, 0, 0, 0, 31, 0, 0);
    checkOutput("hz31", {31'd0, hazard2}, 32'd1);
    applyStimulus(0, 1, 31, 32'h40, 0, 31, 0, 0);
    checkOutput("wb31", ReadData2, 32'h40);
    checkOutput("pend31", {31'd0, pending[31]}, 32'd0);

    applyStimulus(0, 1, 5, 32'd7, 0, 0, 1, 5);
    checkOutput("pend5", {31'd0, pending[5]}, 32'd1);
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0);
    checkOutput("hz5", {31'd0, hazard1}, 32'd1);
    checkOutput("data5", ReadData1, 32'd7);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 3, 0, 1, 9);
    applyStimulus(1, 1, 29, 32'h55, 3, 9, 1, 12);
    applyStimulus(0, 0, 0, 0, 29, 9, 0, 0);
    checkOutput("sp_after_rst", ReadData1, 32'd227);
    checkOutput("pend_after_rst", pending, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 2) != 0), pickReg(), $urandom(),
                    pickReg(), pickReg(),
                    ($urandom_range(0, 2) == 0), pickReg());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
